fpu_pe_batcher: RTL and testbench
=================================

Name: fpu_pe_batcher

Overview:
- Upstream/downstream wrapper for fixed-latency FPU processing elements (fsqrt, fdiv, fcvt) when NUM_PES < NUM_LANES.
- Accepts one NUM_LANES-wide request, issues it to NUM_PES shared PEs in NUM_LANES/NUM_PES consecutive batches, and drives the PE clock-enable.
- Collects the PE results back into lane order and presents one NUM_LANES-wide result with its tag on a valid/ready interface.

Parameters:
- NUM_LANES, 4: request width in lanes.
- NUM_PES, 1: PE count; NUM_PES <= NUM_LANES and NUM_LANES % NUM_PES == 0 (elaboration error otherwise).
- LATENCY, 4: PE pipeline depth in enabled cycles; must be >= 1.
- DATA_IN_WIDTH, 32: per-lane operand width.
- DATA_OUT_WIDTH, 37: per-lane result width (fflags + value).
- TAG_WIDTH, 1: opaque tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  request valid.
- ready_in  out  1  request ready.
- data_in  in  NUM_LANES*DATA_IN_WIDTH  lane operands.
- tag_in  in  TAG_WIDTH  request tag.
- pe_enable  out  1  PE pipeline advance enable.
- pe_data_in  out  NUM_PES*DATA_IN_WIDTH  operands to PEs.
- pe_data_out  in  NUM_PES*DATA_OUT_WIDTH  PE results.
- valid_out  out  1  result valid.
- data_out  out  NUM_LANES*DATA_OUT_WIDTH  lane results.
- tag_out  out  TAG_WIDTH  tag of the result.
- ready_out  in  1  result ready.

Behaviour:
- BATCHES = NUM_LANES/NUM_PES. Batch b, PE p maps to lane b*NUM_PES+p.
- Only one request is in flight at a time.
- States:
  - IDLE: ready_in=1. Accepting a request latches data_in/tag_in and moves to ISSUE with issue_cnt=0.
  - ISSUE: pe_enable=1. pe_data_in = batch issue_cnt. issue_cnt increments each cycle. After batch BATCHES-1, move to COLLECT.
  - COLLECT: pe_enable=1. pe_data_in driven to 0.
  - OUTPUT: pe_enable=0. valid_out=1. data_out/tag_out held stable until ready_out.
- Capture: a batch issued in cycle t appears on pe_data_out in cycle t+LATENCY and is written to lane slots at that cycle's edge. A LATENCY-deep valid/batch-index tracker shifts with pe_enable. Move ISSUE/COLLECT -> OUTPUT at the edge where the last batch is captured.
- Latency: request accepted at end of cycle C0 -> batch 0 issued in C0+1 -> valid_out first high in cycle C0+1+BATCHES+LATENCY.
- OUTPUT exit:
  - valid_out && ready_out -> IDLE.
  - ready_in = IDLE || (OUTPUT && ready_out). A new request accepted in the same cycle as an output handshake goes directly to ISSUE.
- Back-pressure:
  - Holding ready_out low keeps OUTPUT indefinitely with outputs stable.
  - pe_enable stays 0 throughout OUTPUT, so PE state is frozen.
- valid_in is ignored when ready_in=0. Input registers load only on the valid_in && ready_in handshake.
- NUM_PES==NUM_LANES: BATCHES=1, ISSUE lasts one cycle.
- Reset:
  - Values: state=IDLE, valid_out=0, pe_enable=0, ready_in=1, counters and tracker cleared, data_out/tag_out=0.
  - Reset mid-operation discards the in-flight request. Stale PE contents are never captured because the tracker is cleared.

Test Plan:
- NUM_LANES=4, NUM_PES=1, LATENCY=4, bench PE = LATENCY-stage enabled shift register computing x+1. Send data {3,2,1,0}, tag=1 at C0 -> valid_out in C0+9, data_out {4,3,2,1}, tag_out=1; ready_in low C0+1..C0+8.
- Hold ready_out=0 for 5 cycles after valid_out -> outputs stable, pe_enable=0, ready_in=0. Raise ready_out with a new valid_in in the same cycle -> handshake on both sides; next valid_out 9 cycles later.
- NUM_PES=2, NUM_LANES=4 -> pe_data_in carries lanes {1,0} then {3,2} on consecutive cycles; valid_out at C0+7; lane order correct.
- NUM_PES=NUM_LANES=4, LATENCY=1 -> valid_out at C0+3.
- Assert reset in COLLECT, then send a new request -> valid_out=0 during/after reset; ready_in=1 the cycle after reset deasserts; new result contains only new data.
- Toggle valid_in while busy with distinct data -> ignored; result and tag_out match the originally accepted request.

Source files
------------

// File: rtl/fpu_pe_batcher.sv
// fpu_pe_batcher: shares NUM_PES fixed-latency FPU processing elements across a
// NUM_LANES-wide request. The request is issued to the PEs in NUM_LANES/NUM_PES
// consecutive batches. Results are gathered back into lane order and returned
// with the request tag on a valid/ready interface. Only one request is in flight.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   valid_in/ready_in      request handshake; data_in = lane operands, tag_in = tag
//   pe_enable              advance enable for the shared PE pipelines
//   pe_data_in             operands for the current batch (zero when not issuing)
//   pe_data_out            PE results, LATENCY enabled cycles after issue
//   valid_out/ready_out    result handshake; data_out = lane results, tag_out = tag
module fpu_pe_batcher #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned NUM_PES        = 1,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned DATA_IN_WIDTH  = 32,
    parameter int unsigned DATA_OUT_WIDTH = 37,
    parameter int unsigned TAG_WIDTH      = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic [NUM_LANES*DATA_IN_WIDTH-1:0]  data_in,
    input  logic [TAG_WIDTH-1:0]                tag_in,
    output logic                                pe_enable,
    output logic [NUM_PES*DATA_IN_WIDTH-1:0]    pe_data_in,
    input  logic [NUM_PES*DATA_OUT_WIDTH-1:0]   pe_data_out,
    output logic                                valid_out,
    output logic [NUM_LANES*DATA_OUT_WIDTH-1:0] data_out,
    output logic [TAG_WIDTH-1:0]                tag_out,
    input  logic                                ready_out
);

    localparam int unsigned BATCHES = NUM_LANES / NUM_PES;
    localparam int unsigned CNT_W   = (BATCHES > 1) ? $clog2(BATCHES) : 1;
    localparam int unsigned BIN_W   = NUM_PES * DATA_IN_WIDTH;
    localparam int unsigned BOUT_W  = NUM_PES * DATA_OUT_WIDTH;
    localparam int unsigned REQ_W   = NUM_LANES * DATA_IN_WIDTH;

    // Reject unsupported configurations at elaboration.
    if ((NUM_PES > NUM_LANES) || ((NUM_LANES % NUM_PES) != 0)) begin : g_bad_pes
        $error("fpu_pe_batcher: NUM_PES must divide NUM_LANES and be <= NUM_LANES");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("fpu_pe_batcher: LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT,
        S_OUTPUT
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   issue_cnt, issue_cnt_n;
    logic [REQ_W-1:0]   req_data;
    logic [TAG_WIDTH-1:0] req_tag;
    logic [BIN_W-1:0]   pe_data_in_n;
    logic [REQ_W-1:0]   issue_src;

    // Tracker mirrors the PE pipeline: which stage holds a real batch, and which one.
    logic               trk_valid [LATENCY];
    logic [CNT_W-1:0]   trk_idx   [LATENCY];

    // Lane-ordered result slots, one per batch.
    logic [BOUT_W-1:0]  slot [BATCHES];

    logic accept;
    logic capture;
    logic capture_last;

    // Back-to-back: a new request may enter on the same cycle the result leaves.
    assign ready_in     = (state == S_IDLE) || ((state == S_OUTPUT) && ready_out);
    assign accept       = valid_in && ready_in;
    assign capture      = pe_enable && trk_valid[LATENCY-1];
    assign capture_last = capture && (trk_idx[LATENCY-1] == CNT_W'(BATCHES - 1));

    for (genvar b = 0; b < BATCHES; b++) begin : g_slot_map
        assign data_out[b*BOUT_W +: BOUT_W] = slot[b];
    end

    // Next-state, issue counter and next PE operands.
    always_comb begin
        state_n      = state;
        issue_cnt_n  = issue_cnt;
        pe_data_in_n = '0;
        issue_src    = accept ? data_in : req_data;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n     = S_ISSUE;
                    issue_cnt_n = '0;
                end
            end
            S_ISSUE: begin
                if (issue_cnt == CNT_W'(BATCHES - 1)) begin
                    state_n     = S_COLLECT;
                    issue_cnt_n = '0;
                end else begin
                    issue_cnt_n = issue_cnt + CNT_W'(1);
                end
            end
            S_COLLECT: begin
                if (capture_last) begin
                    state_n = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (ready_out) begin
                    state_n     = accept ? S_ISSUE : S_IDLE;
                    issue_cnt_n = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_ISSUE) begin
            pe_data_in_n = BIN_W'(issue_src >> (issue_cnt_n * BIN_W));
        end
    end

    // State, registered outputs, request latch, tracker and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            issue_cnt  <= '0;
            req_data   <= '0;
            req_tag    <= '0;
            valid_out  <= 1'b0;
            pe_enable  <= 1'b0;
            pe_data_in <= '0;
            tag_out    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                trk_valid[i] <= 1'b0;
                trk_idx[i]   <= '0;
            end
            for (int b = 0; b < BATCHES; b++) begin
                slot[b] <= '0;
            end
        end else begin
            state      <= state_n;
            issue_cnt  <= issue_cnt_n;
            valid_out  <= (state_n == S_OUTPUT);
            pe_enable  <= (state_n == S_ISSUE) || (state_n == S_COLLECT);
            pe_data_in <= pe_data_in_n;

            if (accept) begin
                req_data <= data_in;
                req_tag  <= tag_in;
            end

            // Tracker advances only when the PEs advance.
            if (pe_enable) begin
                trk_valid[0] <= (state == S_ISSUE);
                trk_idx[0]   <= issue_cnt;
                for (int i = 1; i < LATENCY; i++) begin
                    trk_valid[i] <= trk_valid[i-1];
                    trk_idx[i]   <= trk_idx[i-1];
                end
            end

            if (capture) begin
                slot[trk_idx[LATENCY-1]] <= pe_data_out;
            end

            if (capture_last) begin
                tag_out <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_pe_batcher.sv
// Testbench for fpu_pe_batcher: three configurations (4 lanes over 1 PE / 4 deep,
// 2 PEs / 4 deep, 4 PEs / 1 deep), each with an x+1 PE model, a scoreboard queue
// fed by the stimulus on every accepted request, and an independent monitor.
module tb_fpu_pe_batcher;

    localparam int NL  = 4;
    localparam int DIW = 32;
    localparam int DOW = 37;
    localparam int TW  = 1;

    typedef struct {
        logic [NL*DIW-1:0] din;
        logic [TW-1:0]     tag;
        int                c0;
    } exp_t;

    logic clk;
    int   n_cmp;
    int   n_bad;
    bit   done [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int cfg, input string nm, input logic [191:0] act,
                         input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, nm, act, exp);
        end
    endtask

    // Reference: every lane result is its operand plus one, in lane order.
    function automatic logic [NL*DOW-1:0] model(input logic [NL*DIW-1:0] d);
        logic [NL*DOW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            r[l*DOW +: DOW] = DOW'(d[l*DIW +: DIW]) + DOW'(1);
        end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int NP  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int LAT = (g == 2) ? 1 : 4;
        localparam int B   = NL / NP;
        localparam int BW  = NP * DIW;
        localparam int BOW = NP * DOW;

        logic              reset;
        logic              valid_in;
        logic              ready_in;
        logic [NL*DIW-1:0] data_in;
        logic [TW-1:0]     tag_in;
        logic              pe_enable;
        logic [BW-1:0]     pe_data_in;
        logic [BOW-1:0]    pe_data_out;
        logic              valid_out;
        logic [NL*DOW-1:0] data_out;
        logic [TW-1:0]     tag_out;
        logic              ready_out;

        fpu_pe_batcher #(
            .NUM_LANES(NL), .NUM_PES(NP), .LATENCY(LAT),
            .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW), .TAG_WIDTH(TW)
        ) dut (
            .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
            .data_in(data_in), .tag_in(tag_in), .pe_enable(pe_enable),
            .pe_data_in(pe_data_in), .pe_data_out(pe_data_out),
            .valid_out(valid_out), .data_out(data_out), .tag_out(tag_out),
            .ready_out(ready_out)
        );

        // PE model: LAT-stage enabled pipeline computing x+1 per PE; never reset.
        logic [BOW-1:0] pe_pipe [LAT];
        always @(posedge clk) begin
            if (pe_enable) begin
                for (int p = 0; p < NP; p++) begin
                    pe_pipe[0][p*DOW +: DOW] <= DOW'(pe_data_in[p*DIW +: DIW]) + DOW'(1);
                end
                for (int i = 1; i < LAT; i++) begin
                    pe_pipe[i] <= pe_pipe[i-1];
                end
            end
        end
        assign pe_data_out = pe_pipe[LAT-1];

        int   cyc;
        exp_t sb [$];
        bit   pend;
        exp_t pend_e;

        initial cyc = 0;
        always @(posedge clk) cyc++;

        // One cycle of stimulus; a handshake seen this cycle is queued next cycle.
        task automatic drive(input bit v, input logic [NL*DIW-1:0] d,
                             input logic [TW-1:0] t, input bit r);
            @(posedge clk);
            #1;
            valid_in  = v;
            data_in   = d;
            tag_in    = t;
            ready_out = r;
            if (pend) begin
                sb.push_back(pend_e);
                pend = 1'b0;
            end
            @(negedge clk);
            if (!reset && valid_in && ready_in) begin
                pend   = 1'b1;
                pend_e = '{din: data_in, tag: tag_in, c0: cyc};
            end
        endtask

        task automatic do_reset();
            @(posedge clk);
            #1;
            reset     = 1'b1;
            valid_in  = 1'b0;
            ready_out = 1'b0;
            pend      = 1'b0;
            sb.delete();
            @(posedge clk);
            @(negedge clk);
            check(g, "rst_valid_out", 192'(valid_out), 192'(0));
            check(g, "rst_pe_enable", 192'(pe_enable), 192'(0));
            check(g, "rst_ready_in",  192'(ready_in),  192'(1));
            check(g, "rst_data_out",  192'(data_out),  192'(0));
            check(g, "rst_tag_out",   192'(tag_out),   192'(0));
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
            check(g, "post_rst_ready_in",  192'(ready_in),  192'(1));
            check(g, "post_rst_valid_out", 192'(valid_out), 192'(0));
        endtask

        initial begin : stim
            logic [NL*DIW-1:0] d;
            reset     = 1'b1;
            valid_in  = 1'b0;
            data_in   = '0;
            tag_in    = '0;
            ready_out = 1'b0;
            pend      = 1'b0;
            repeat (2) @(posedge clk);
            do_reset();

            // Directed request {3,2,1,0}, held under back-pressure, then back-to-back.
            d = {32'd3, 32'd2, 32'd1, 32'd0};
            drive(1'b1, d, 1'b1, 1'b0);
            repeat (B + LAT + 5) drive(1'b0, '0, '0, 1'b0);
            d = {32'd13, 32'd12, 32'd11, 32'd10};
            drive(1'b1, d, 1'b0, 1'b1);
            repeat (B + LAT + 2) drive(1'b0, '0, '0, 1'b1);

            // Reset while collecting, then a fresh request must carry only new data.
            d = {32'hdead0003, 32'hdead0002, 32'hdead0001, 32'hdead0000};
            drive(1'b1, d, 1'b1, 1'b1);
            repeat (B) drive(1'b0, '0, '0, 1'b1);
            do_reset();
            d = {32'h00a00003, 32'h00a00002, 32'h00a00001, 32'h00a00000};
            drive(1'b1, d, 1'b0, 1'b1);
            repeat (B + LAT + 2) drive(1'b0, '0, '0, 1'b1);

            // Random traffic: valid_in toggles with fresh data even while busy.
            for (int i = 0; i < 200; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                drive(1'(($urandom % 2)), d, TW'($urandom), ($urandom % 4) != 0);
            end

            // Drain.
            for (int i = 0; i < 100 && (pend || sb.size() != 0); i++) begin
                drive(1'b0, '0, '0, 1'b1);
            end
            check(g, "drain_pending", 192'(sb.size() + int'(pend)), 192'(0));
            done[g] = 1'b1;
        end

        initial begin : mon
            bit                active;
            logic [NL*DOW-1:0] snap_d;
            logic [TW-1:0]     snap_t;
            exp_t              e;
            int                k;
            logic [BW-1:0]     eb;
            active = 1'b0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    active = 1'b0;
                end else if (valid_out) begin
                    check(g, "out_pe_enable", 192'(pe_enable), 192'(0));
                    check(g, "out_ready_in",  192'(ready_in),  192'(ready_out));
                    if (sb.size() == 0) begin
                        check(g, "unexpected_valid_out", 192'(valid_out), 192'(0));
                    end else begin
                        e = sb[0];
                        if (!active) begin
                            active = 1'b1;
                            snap_d = data_out;
                            snap_t = tag_out;
                            check(g, "latency", 192'(cyc), 192'(e.c0 + 1 + B + LAT));
                        end else begin
                            check(g, "hold_data", 192'(data_out), 192'(snap_d));
                            check(g, "hold_tag",  192'(tag_out),  192'(snap_t));
                        end
                        if (ready_out) begin
                            check(g, "data_out", 192'(data_out), 192'(model(e.din)));
                            check(g, "tag_out",  192'(tag_out),  192'(e.tag));
                            void'(sb.pop_front());
                            active = 1'b0;
                        end
                    end
                end else begin
                    active = 1'b0;
                    if (sb.size() == 0) begin
                        check(g, "idle_ready_in", 192'(ready_in), 192'(1));
                    end else begin
                        e = sb[0];
                        k = cyc - e.c0 - 1;
                        check(g, "busy_ready_in",  192'(ready_in),  192'(0));
                        check(g, "busy_pe_enable", 192'(pe_enable), 192'(1));
                        if (k >= B + LAT) begin
                            check(g, "valid_out_late", 192'(k), 192'(B + LAT - 1));
                        end else if (k < B) begin
                            eb = BW'(e.din >> (k * BW));
                            check(g, "pe_data_in_batch", 192'(pe_data_in), 192'(eb));
                        end else begin
                            check(g, "pe_data_in_zero", 192'(pe_data_in), 192'(0));
                        end
                    end
                end
            end
        end
    end

    initial begin : finisher
        n_cmp = 0;
        n_bad = 0;
        wait (done[0] && done[1] && done[2]);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: bench did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
